// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared compare-mode encodings, FSM states and outcome helper
package alu_pkg;

  localparam logic [2:0] CMP_EQ      = 3'd0;
  localparam logic [2:0] CMP_NE      = 3'd1;
  localparam logic [2:0] CMP_LT      = 3'd2;
  localparam logic [2:0] CMP_LTU     = 3'd3;
  localparam logic [2:0] CMP_GE      = 3'd4;
  localparam logic [2:0] CMP_GEU     = 3'd5;
  localparam logic [2:0] CMP_RSVD_LO = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_signed_mode(input logic [2:0] m);
    return (m == CMP_LT) || (m == CMP_GE);
  endfunction

  // Final compare outcome from the first-difference flags; reserved modes give 0.
  function automatic logic cmp_outcome(input logic [2:0] m, input logic diff, input logic lt);
    logic r;
    r = 1'b0;
    case (m)
      CMP_EQ:          r = ~diff;
      CMP_NE:          r = diff;
      CMP_LT, CMP_LTU: r = lt & diff;
      CMP_GE, CMP_GEU: r = ~(lt & diff);
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// rtl/chunk_cmp.sv - combinational compare of one CHUNK-bit slice
module chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] ca,
  input  logic [CHUNK-1:0] cb,
  input  logic             signed_top,
  output logic             neq,
  output logic             lt
);

  assign neq = (ca != cb);

  // Unsigned less-than, except the top chunk of a signed compare where differing sign bits decide.
  always_comb begin
    lt = (ca < cb);
    if (signed_top && (ca[CHUNK-1] != cb[CHUNK-1])) begin
      lt = ca[CHUNK-1];
    end
  end

endmodule

// File: rtl/cmp_iter.sv
// rtl/cmp_iter.sv - multi-cycle MSB-first magnitude/equality comparator with early exit
module cmp_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  output logic             busy,
  output logic             done,
  output logic             result,
  output logic             equal,
  output logic             z,
  output logic             n,
  output logic             err
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  state_e            state, state_nx;
  logic [WIDTH-1:0]  ra, rb;
  logic [2:0]        rmode;
  logic [IDXW-1:0]   idx;
  logic [CHUNK-1:0]  ca, cb;
  logic              c_neq, c_lt;
  logic              signed_top;
  logic              last;
  logic              outcome;

  assign ca         = ra[idx*CHUNK +: CHUNK];
  assign cb         = rb[idx*CHUNK +: CHUNK];
  assign signed_top = is_signed_mode(rmode) && (idx == IDX_TOP);
  assign last       = c_neq || (idx == '0);
  assign outcome    = cmp_outcome(rmode, c_neq, c_lt);

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .ca         (ca),
    .cb         (cb),
    .signed_top (signed_top),
    .neq        (c_neq),
    .lt         (c_lt)
  );

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state: accept start only in IDLE, leave RUN on first difference or last chunk.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (last)  state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand capture, chunk walk, and flag registers loaded as the walk finishes so they are valid with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra     <= '0;
      rb     <= '0;
      rmode  <= CMP_EQ;
      idx    <= '0;
      result <= 1'b0;
      equal  <= 1'b0;
      z      <= 1'b0;
      n      <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            rmode <= mode;
            idx   <= IDX_TOP;
          end
        end
        ST_RUN: begin
          if (last) begin
            result <= outcome;
            equal  <= ~c_neq;
            z      <= ~outcome;
            n      <= 1'b0;
            err    <= (rmode >= CMP_RSVD_LO);
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_iter.sv
// tb/tb_cmp_iter.sv - directed scoreboard bench for cmp_iter
module tb_cmp_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  mode = '0;
  logic        busy, done, result, equal, z, n, err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string tag;
    logic  r;
    logic  eq;
    logic  er;
    int    lat;
  } exp_t;

  exp_t sb[$];

  cmp_iter #(.WIDTH(32), .CHUNK(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .mode   (mode),
    .busy   (busy),
    .done   (done),
    .result (result),
    .equal  (equal),
    .z      (z),
    .n      (n),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [31:0] ta, input logic [31:0] tb_, input logic [2:0] tm,
                       output logic r, output logic eq, output logic er, output int lat);
    int m;
    eq = (ta == tb_);
    er = (tm >= 3'd6);
    case (tm)
      3'd0: r = eq;
      3'd1: r = !eq;
      3'd2: r = ($signed(ta) < $signed(tb_));
      3'd3: r = (ta < tb_);
      3'd4: r = !($signed(ta) < $signed(tb_));
      3'd5: r = !(ta < tb_);
      default: r = 1'b0;
    endcase
    m = 0;
    for (int k = 3; k >= 0; k--) begin
      m++;
      if (ta[k*8 +: 8] != tb_[k*8 +: 8]) break;
    end
    lat = m + 1;
  endtask

  task automatic run(input string tag, input logic [31:0] ta, input logic [31:0] tb_, input logic [2:0] tm);
    exp_t e;
    exp_t got;
    int   cyc;
    logic hold_r;
    model(ta, tb_, tm, e.r, e.eq, e.er, e.lat);
    e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    a = ta; b = tb_; mode = tm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; mode = 3'($urandom);
    cyc = 1;
    check({tag, "/busy_run"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    got = sb.pop_front();
    check({got.tag, "/latency"}, cyc, got.lat);
    check({got.tag, "/result"}, 32'(result), 32'(got.r));
    check({got.tag, "/equal"}, 32'(equal), 32'(got.eq));
    check({got.tag, "/z"}, 32'(z), 32'(!got.r));
    check({got.tag, "/n"}, 32'(n), 32'd0);
    check({got.tag, "/err"}, 32'(err), 32'(got.er));
    check({got.tag, "/busy_done"}, 32'(busy), 32'd0);
    hold_r = got.r;
    @(posedge clk); #1;
    check({got.tag, "/done_pulse"}, 32'(done), 32'd0);
    check({got.tag, "/result_hold"}, 32'(result), 32'(hold_r));
  endtask

  initial begin
    int dones;
    logic seen_r;

    repeat (2) @(posedge clk);
    #1;
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/flags", {27'd0, result, equal, z, n, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("eq_full",     32'h0000_0001, 32'h0000_0001, 3'd0);
    run("lt_signed",   32'h8000_0000, 32'h0000_0001, 3'd2);
    run("ltu",         32'h8000_0000, 32'h0000_0001, 3'd3);
    run("ge_low",      32'hFFFF_FFFF, 32'hFFFF_FFFE, 3'd4);
    run("ge_low_swap", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'd4);
    run("ne_neg_eq",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1);
    run("rsvd7",       32'h1234_5678, 32'h1234_5679, 3'd7);
    run("rsvd6",       32'h0000_0000, 32'h0000_0000, 3'd6);
    run("lt_mid",      32'hFFFF_0000, 32'hFFFF_0100, 3'd2);
    run("geu_top",     32'h7F00_0000, 32'h8000_0000, 3'd5);
    run("ge_sgn",      32'h7F00_0000, 32'h8000_0000, 3'd4);
    run("eq_diff",     32'h00AB_0000, 32'h00AC_0000, 3'd0);

    // Second start while busy must be ignored.
    @(negedge clk);
    a = 32'hCAFE_F00D; b = 32'hCAFE_F00D; mode = 3'd0; start = 1'b1;
    @(negedge clk);
    a = 32'h0000_0000; b = 32'hFFFF_FFFF; mode = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    seen_r = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        dones++;
        seen_r = result;
      end
    end
    check("busy_start/done_count", dones, 32'd1);
    check("busy_start/result", 32'(seen_r), 32'd1);
    check("busy_start/equal", 32'(equal), 32'd1);

    // Reset during RUN: outputs clear at once, no done follows.
    @(negedge clk);
    a = 32'h0; b = 32'h0; mode = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort/busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/done", 32'(done), 32'd0);
    check("abort/flags", {27'd0, result, equal, z, n, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    check("abort/no_done", dones, 32'd0);
    run("after_abort", 32'h0000_0005, 32'h0000_0003, 3'd5);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_iter.md
Name: cmp_iter

Overview:
- Parametrised, multi-cycle magnitude/equality comparator for the ALU datapath. Generalises the combinational 32-bit equality check.
- Supports WIDTH-bit operands, six compare modes (signed/unsigned), and a start/busy/done handshake.
- Examines CHUNK bits per cycle from the MSB down and exits early on the first differing chunk. This trades latency for area on wide operands.
- Produces the ALU-style flags equal, z and n alongside the 1-bit compare result.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; NCHUNK = WIDTH/CHUNK, must be >= 1.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request a compare; sampled only when busy=0.
- a, input, WIDTH, operand A; captured on an accepted start.
- b, input, WIDTH, operand B; captured on an accepted start.
- mode, input, 3, 0=EQ 1=NE 2=LT(signed) 3=LTU 4=GE(signed) 5=GEU 6,7=reserved.
- busy, output, 1, high from the cycle after an accepted start until done.
- done, output, 1, one-cycle pulse when results become valid.
- result, output, 1, compare outcome for the captured mode.
- equal, output, 1, 1 when captured a == b.
- z, output, 1, zero flag: 1 when result == 0.
- n, output, 1, negative flag; always 0 because result is non-negative.
- err, output, 1, 1 when the captured mode was reserved.

Behaviour:
- Reset, asynchronous when rst_n=0:
  - State returns to IDLE; busy=0, done=0.
  - result=0, equal=0, z=0, n=0, err=0.
  - Operand registers, chunk index and lt/diff registers are cleared.
  - Reset asserted mid-RUN aborts the operation; no done pulse is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches a, b and mode, sets idx=NCHUNK-1 and diff=0, and moves to RUN.
  - start=0 stays in IDLE.
  - Result outputs hold their last values.
- RUN, once per cycle, compares chunk idx of A and B (bits idx*CHUNK+CHUNK-1 .. idx*CHUNK):
  - Chunks differ: set diff=1. Set lt as follows:
    - Signed mode with idx==NCHUNK-1 and differing sign bits: lt = a[WIDTH-1].
    - Otherwise: lt = unsigned(chunk_a < chunk_b).
    - Go to DONE.
  - Chunks equal and idx==0: diff=0, go to DONE.
  - Chunks equal otherwise: idx decrements, stay in RUN.
- DONE, one cycle:
  - done=1 and busy=0 in this cycle.
  - equal = ~diff.
  - result:
    - EQ: ~diff
    - NE: diff
    - LT/LTU: lt & diff
    - GE/GEU: ~(lt & diff)
    - reserved: 0, with err=1
  - z = ~result; n = 0.
  - Next state is IDLE.
- Output timing:
  - result, equal, z, n and err are registered, update on the DONE edge, and hold until the next DONE or reset.
  - With m = number of chunks examined, done is high in cycle m+1 after the start edge.
  - Minimum latency is 2 cycles (m=1); maximum is NCHUNK+1.
- Boundary and handshake rules:
  - start while busy=1, or in the DONE cycle, is ignored; there is no queueing.
  - a, b and mode may change freely after acceptance.
  - NCHUNK=1: RUN lasts exactly one cycle.
  - Signed handling applies only to the top chunk. Lower chunks are always compared unsigned, which is correct for two's complement.

Decomposition:
- Shared package alu_pkg:
  - mode encodings CMP_EQ..CMP_GEU and CMP_RSVD range.
  - state encoding for IDLE, RUN, DONE.
- Sub-module chunk_cmp: combinational, CHUNK-bit inputs, outputs neq and lt, with a signed_top input for sign handling. It is instantiated once, fed by the idx-selected slice.

Test Plan:
- Full-length equal: WIDTH=32, CHUNK=8, EQ, a=0x00000001, b=0x00000001 -> done at cycle 5, result=1, equal=1, z=0, n=0, err=0.
- Early exit, signed vs unsigned: a=0x80000000, b=0x00000001.
  - LT -> done at cycle 2, result=1, z=0.
  - Repeat with LTU -> done at cycle 2, result=0, z=1.
- Difference in the lowest chunk: a=0xFFFFFFFF, b=0xFFFFFFFE, GE -> done at cycle 5, result=1, equal=0.
  - Swap operands -> result=0, z=1.
- Negatives equal: a=b=0xFFFFFFFF, NE -> done at cycle 5, result=0, equal=1, z=1.
- Reserved mode and handshake:
  - mode=7 -> err=1, result=0, z=1.
  - A second start pulsed while busy is ignored; exactly one done is observed.
- Reset mid-operation: assert rst_n=0 during RUN -> busy, done and all flags read 0 immediately without a clock edge; no done pulse follows; the next start completes normally.
